// File: rtl/jtvigil_pcm_fetch_if.sv
// PCM sample request port and SDRAM ROM read port of the PCM fetcher.
interface jtvigil_pcm_fetch_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          pcm_cs;
    logic [AW-1:0] pcm_addr;
    logic [DW-1:0] pcm_data;
    logic          pcm_ok;
    logic          sdram_cs;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data;
    logic          sdram_ok;

    // Fetcher side: serves PCM sample requests, issues SDRAM reads
    modport slave (
        input  pcm_cs, pcm_addr, sdram_data, sdram_ok,
        output pcm_data, pcm_ok, sdram_cs, sdram_addr
    );

    // Environment side: sound subsystem plus SDRAM ROM slot
    modport master (
        output pcm_cs, pcm_addr, sdram_data, sdram_ok,
        input  pcm_data, pcm_ok, sdram_cs, sdram_addr
    );
endinterface

// File: rtl/jtvigil_pcm_fetch.sv
// PCM sample fetcher: turns PCM address changes into SDRAM ROM reads and
// keeps a one-byte prefetch of the next sequential sample.
module jtvigil_pcm_fetch #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    jtvigil_pcm_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREF
    } state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] buf_addr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] data;
    logic [DW-1:0] buf_data;
    logic          cur_valid;
    logic          buf_valid;
    logic          ok_reg;
    logic          req;
    logic          miss;
    logic          hit;

    assign miss = bus.pcm_cs & (~cur_valid | (bus.pcm_addr != cur_addr));
    assign hit  = buf_valid & (buf_addr == bus.pcm_addr);

    // ok is qualified by the live address so it falls in the same cycle the
    // address moves away from the byte held in pcm_data
    assign bus.pcm_ok     = ok_reg & bus.pcm_cs & (bus.pcm_addr == cur_addr);
    assign bus.pcm_data   = data;
    assign bus.sdram_cs   = req;
    assign bus.sdram_addr = req_addr;

    // Request sequencer: demand fetch, next-byte prefetch and buffer hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            buf_addr  <= '0;
            req_addr  <= '0;
            data      <= '0;
            buf_data  <= '0;
            cur_valid <= 1'b0;
            buf_valid <= 1'b0;
            ok_reg    <= 1'b0;
            req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        if (hit) begin
                            cur_addr  <= bus.pcm_addr;
                            data      <= buf_data;
                            cur_valid <= 1'b1;
                            ok_reg    <= 1'b1;
                            buf_valid <= 1'b0;
                        end else begin
                            // a non-sequential jump makes the buffered byte
                            // useless; dropping it lets the new stream prefetch
                            ok_reg    <= 1'b0;
                            buf_valid <= 1'b0;
                            req       <= 1'b1;
                            req_addr  <= bus.pcm_addr;
                            state     <= FETCH;
                        end
                    end else if (bus.pcm_cs && !buf_valid) begin
                        req      <= 1'b1;
                        req_addr <= cur_addr + AW'(1);
                        state    <= PREF;
                    end
                end
                FETCH: begin
                    if (bus.sdram_ok) begin
                        data      <= bus.sdram_data;
                        cur_addr  <= req_addr;
                        cur_valid <= 1'b1;
                        ok_reg    <= 1'b1;
                        req       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                PREF: begin
                    if (bus.sdram_ok) begin
                        buf_data  <= bus.sdram_data;
                        buf_addr  <= req_addr;
                        buf_valid <= 1'b1;
                        req       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtvigil_pcm_fetch.sv
// Bench for jtvigil_pcm_fetch: SDRAM ROM model with random latency, protocol
// monitor, and a scoreboard of expected (address, byte) pairs per pcm_ok event.
module tb_jtvigil_pcm_fetch;
    localparam int AW = 16;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtvigil_pcm_fetch_if #(.AW(AW), .DW(DW)) bus ();
    jtvigil_pcm_fetch #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int            checks    = 0;
    int            failures  = 0;
    int            fixed_lat = -1;
    logic [DW-1:0] rom [0:(1<<AW)-1];
    exp_t          sb_q [$];
    logic [AW-1:0] req_q [$];
    logic [AW-1:0] last_served = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // SDRAM ROM slot: random or fixed latency, garbage on sdram_ok while idle
    initial begin : sdram_model
        int   lat;
        int   cnt;
        logic busy;
        busy = 1'b0;
        lat  = 0;
        cnt  = 0;
        bus.sdram_ok   = 1'b0;
        bus.sdram_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sdram_cs && !rst) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (cnt >= lat) begin
                    bus.sdram_ok   = 1'b1;
                    bus.sdram_data = rom[bus.sdram_addr];
                end else begin
                    bus.sdram_ok   = 1'b0;
                    bus.sdram_data = DW'($urandom);
                    cnt++;
                end
            end else begin
                busy = 1'b0;
                bus.sdram_ok   = 1'($urandom_range(0, 1));
                bus.sdram_data = DW'($urandom);
            end
        end
    end

    // SDRAM handshake rules; logs each new request address
    initial begin : proto_mon
        logic          pcs;
        logic          pok;
        logic [AW-1:0] paddr;
        pcs   = 1'b0;
        pok   = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pcs = 1'b0;
                pok = 1'b0;
            end else begin
                if (pcs && !pok) begin
                    check("sdram_cs held until sdram_ok", 32'(bus.sdram_cs), 32'd1);
                    check("sdram_addr stable during request", 32'(bus.sdram_addr), 32'(paddr));
                end
                if (pcs && pok)
                    check("sdram_cs gap after sdram_ok", 32'(bus.sdram_cs), 32'd0);
                if (bus.sdram_cs && !pcs)
                    req_q.push_back(bus.sdram_addr);
                pcs   = bus.sdram_cs;
                pok   = bus.sdram_ok;
                paddr = bus.sdram_addr;
            end
        end
    end

    // Scoreboard: every new pcm_ok presentation consumes one expectation
    initial begin : sb_mon
        logic          pok;
        logic [AW-1:0] paddr;
        exp_t          e;
        pok   = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (bus.pcm_ok && !(pok && paddr == bus.pcm_addr)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected pcm_ok: addr %0h data %0h, none expected (t=%0t)",
                             bus.pcm_addr, bus.pcm_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("pcm_ok address", 32'(bus.pcm_addr), 32'(e.addr));
                    check("pcm_data", 32'(bus.pcm_data), 32'(e.data));
                end
            end
            pok   = bus.pcm_ok;
            paddr = bus.pcm_addr;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a);
        exp_t e;
        e.addr = a;
        e.data = rom[a];
        sb_q.push_back(e);
    endtask

    task automatic set_addr(input logic [AW-1:0] a, input bit push);
        logic [AW-1:0] old;
        old = bus.pcm_addr;
        bus.pcm_addr = a;
        if (push && bus.pcm_cs)
            push_exp(a);
        #1;
        if (a != old && a != last_served)
            check("pcm_ok drops with address change", 32'(bus.pcm_ok), 32'd0);
    endtask

    task automatic wait_served(input string name, input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d pcm responses outstanding after %0d cycles (t=%0t)",
                     name, sb_q.size(), limit, $time);
            sb_q.delete();
        end
        last_served = bus.pcm_addr;
    endtask

    task automatic expect_req(input logic [AW-1:0] a, input string name);
        int n;
        n = 0;
        while (req_q.size() == 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (req_q.size() == 0) fail_now(name);
        else check(name, 32'(req_q.pop_front()), 32'(a));
    endtask

    task automatic wait_cs_low();
        int n;
        n = 0;
        while (bus.sdram_cs && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (bus.sdram_cs) fail_now("request completion");
    endtask

    task automatic wait_sdram_ok();
        int n;
        n = 0;
        while (!(bus.sdram_cs && bus.sdram_ok) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.sdram_cs && bus.sdram_ok)) fail_now("sdram_ok");
    endtask

    // Address change that must be served from the prefetch buffer in one cycle
    task automatic hit_check(input logic [AW-1:0] a);
        sync();
        set_addr(a, 1'b1);
        sync();
        check("prefetch hit latency", 32'(bus.pcm_ok), 32'd1);
        check("no SDRAM request on hit", 32'(req_q.size()), 32'd0);
        wait_served("hit", 20);
    endtask

    function automatic logic [AW-1:0] rand_new();
        logic [AW-1:0] r;
        r = AW'($urandom);
        if (r == bus.pcm_addr || r == last_served)
            r = r ^ 16'h00F0;
        return r;
    endfunction

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [AW-1:0] r;
        int            sel;
        for (int i = 0; i < (1 << AW); i++)
            rom[i] = DW'($urandom);
        rom[16'h1234] = 8'hA5;
        rom[16'h1235] = 8'h5A;
        bus.pcm_cs   = 1'b1;
        bus.pcm_addr = 16'h1234;
        fixed_lat    = 5;

        // reset values
        #2;
        check("reset pcm_data", 32'(bus.pcm_data), 32'd0);
        check("reset pcm_ok", 32'(bus.pcm_ok), 32'd0);
        check("reset sdram_cs", 32'(bus.sdram_cs), 32'd0);
        check("reset sdram_addr", 32'(bus.sdram_addr), 32'd0);
        tick(3);
        rst = 1'b0;
        push_exp(16'h1234);

        // demand fetch, then prefetch of the next byte after a gap
        expect_req(16'h1234, "demand request 1234");
        wait_sdram_ok();
        @(negedge clk);
        check("pcm_ok one cycle after sdram_ok", 32'(bus.pcm_ok), 32'd1);
        check("sdram_cs gap before prefetch", 32'(bus.sdram_cs), 32'd0);
        wait_served("demand 1234", 40);
        expect_req(16'h1235, "prefetch request 1235");
        wait_cs_low();

        // sequential hit, prefetch of 1236 is slow
        fixed_lat = 6;
        hit_check(16'h1235);
        expect_req(16'h1236, "prefetch request 1236");

        // jump while the prefetch is in flight: completes, then demand
        sync();
        set_addr(16'h4000, 1'b1);
        expect_req(16'h4000, "demand request 4000 after prefetch");
        wait_served("demand 4000", 60);
        expect_req(16'h4001, "prefetch request 4001");
        wait_cs_low();

        // address wrap on prefetch
        fixed_lat = -1;
        sync();
        set_addr(16'hFFFF, 1'b1);
        expect_req(16'hFFFF, "demand request FFFF");
        wait_served("demand FFFF", 40);
        expect_req(16'h0000, "prefetch wraps to 0000");
        wait_cs_low();
        hit_check(16'h0000);
        expect_req(16'h0001, "prefetch request 0001");
        wait_cs_low();

        // pcm_cs drops during a fetch
        fixed_lat = 4;
        sync();
        set_addr(16'h0100, 1'b1);
        expect_req(16'h0100, "demand request 0100");
        sync();
        bus.pcm_cs = 1'b0;
        sb_q.delete();
        #1;
        check("pcm_ok masked by pcm_cs", 32'(bus.pcm_ok), 32'd0);
        wait_cs_low();
        sync();
        check("pcm_ok masked after completion", 32'(bus.pcm_ok), 32'd0);
        tick(2);
        bus.pcm_cs = 1'b1;
        push_exp(16'h0100);
        sync();
        check("pcm_ok after pcm_cs returns", 32'(bus.pcm_ok), 32'd1);
        check("no refetch after pcm_cs returns", 32'(req_q.size()), 32'd0);
        wait_served("reselect 0100", 20);
        expect_req(16'h0101, "prefetch request 0101");
        wait_cs_low();

        // reset in the middle of a request
        fixed_lat = 6;
        hit_check(16'h0101);
        expect_req(16'h0102, "prefetch request 0102");
        sync();
        set_addr(16'h0102, 1'b0);
        tick(1);
        rst = 1'b1;
        #1;
        check("sdram_cs cleared by reset", 32'(bus.sdram_cs), 32'd0);
        check("pcm_ok cleared by reset", 32'(bus.pcm_ok), 32'd0);
        check("pcm_data cleared by reset", 32'(bus.pcm_data), 32'd0);
        req_q.delete();
        sb_q.delete();
        tick(2);
        rst = 1'b0;
        push_exp(16'h0102);
        expect_req(16'h0102, "demand after reset");
        wait_served("after reset 0102", 40);
        expect_req(16'h0103, "prefetch request 0103");
        wait_cs_low();

        // buffered byte must not survive a reset
        sync();
        bus.pcm_cs = 1'b0;
        tick(1);
        set_addr(16'h0103, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        bus.pcm_cs = 1'b1;
        push_exp(16'h0103);
        expect_req(16'h0103, "demand instead of stale buffer");
        wait_served("after reset 0103", 40);
        expect_req(16'h0104, "prefetch request 0104");
        wait_cs_low();

        // random streams, jumps, deselects and interrupted changes
        fixed_lat = -1;
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 9));
            sync();
            if (sel < 5) begin
                set_addr(bus.pcm_addr + 16'd1, 1'b1);
            end else if (sel < 7) begin
                set_addr(rand_new(), 1'b1);
            end else if (sel == 7) begin
                bus.pcm_cs = 1'b0;
                tick(int'($urandom_range(1, 4)));
                bus.pcm_cs = 1'b1;
                push_exp(bus.pcm_addr);
            end else if (sel == 8) begin
                set_addr(bus.pcm_addr ^ 16'h8000, 1'b0);
                tick(1);
                r = rand_new();
                if (r == bus.pcm_addr) r = r ^ 16'h0001;
                set_addr(r, 1'b1);
            end else begin
                tick(int'($urandom_range(1, 6)));
            end
            wait_served("random", 200);
        end
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtvigil_pcm_fetch.md
Name: jtvigil_pcm_fetch

Overview:
Sits between the sound subsystem's PCM address register (pcm_addr/pcm_cs/pcm_data/pcm_ok) and the SDRAM ROM slot holding the ADPCM/PCM samples. It turns address changes into SDRAM read requests and returns the byte with a clean ok pulse. A one-byte next-address prefetch lets a sequential sample stream get its data one clock after each address increment. The PCM edge detector downstream relies on pcm_ok dropping as soon as the address changes, and this block guarantees it.

Parameters:
AW, 16, sample address width (pcm side and SDRAM side)
DW, 8, sample data width

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous reset, active high
pcm_cs  in  1  fetch enable; no new SDRAM requests while low
pcm_addr  in  AW  requested sample address
pcm_data  out  DW  sample byte for pcm_addr, registered
pcm_ok  out  1  pcm_data valid for current pcm_addr
sdram_cs  out  1  SDRAM read request, registered
sdram_addr  out  AW  SDRAM read address, registered, stable while sdram_cs high
sdram_data  in  DW  SDRAM read data
sdram_ok  in  1  SDRAM data valid for sdram_addr while sdram_cs high

Behaviour:
- Reset values: pcm_data=0, pcm_ok=0, sdram_cs=0, sdram_addr=0. Internal state: state=IDLE, cur_addr=0, cur_valid=0, buf_valid=0.
- pcm_ok is combinational: ok_reg & pcm_cs & (pcm_addr==cur_addr). It falls in the same cycle pcm_addr changes and never shows stale data for a new address.
- SDRAM handshake:
  - Raise sdram_cs with sdram_addr stable and hold it until the first cycle with sdram_ok=1.
  - Capture sdram_data in that cycle and drop sdram_cs on the next edge.
  - Keep sdram_cs low for at least 1 cycle between requests.
  - Never abort a request.
  - Ignore sdram_ok while sdram_cs=0.
- States:
  - IDLE: entered after reset and after every request completes.
    - Miss: pcm_cs=1 and (!cur_valid or pcm_addr!=cur_addr).
      - If buf_valid and buf_addr==pcm_addr (hit), then on the next edge load cur_addr<=pcm_addr, pcm_data<=buf_data, ok_reg<=1, buf_valid<=0. Latency is 1 cycle from the address change to pcm_ok=1.
      - Otherwise (demand miss), set ok_reg<=0, issue a request for pcm_addr, and go to FETCH.
    - No miss, pcm_cs=1, buf_valid=0: issue a prefetch of cur_addr+1 and go to PREF. The increment is modulo 2^AW, so 16'hFFFF prefetches 16'h0000.
    - pcm_cs=0: stay in IDLE, issue nothing. cur_valid and buf_valid are retained.
  - FETCH: on sdram_ok, set pcm_data<=sdram_data, cur_addr<=sdram_addr, cur_valid<=1, ok_reg<=1, then go to IDLE. If pcm_addr moved meanwhile, the comparator keeps pcm_ok low and IDLE re-fetches.
  - PREF: on sdram_ok, set buf_data<=sdram_data, buf_addr<=sdram_addr, buf_valid<=1, then go to IDLE. If pcm_addr changed to the prefetch address during PREF, IDLE serves it as a hit one cycle after completion.
- Simultaneous events:
  - Address change in the same cycle as sdram_ok: the completion is processed first, and the change is evaluated in IDLE on the following cycle.
  - pcm_cs falling during FETCH/PREF: the request completes, data is stored, and pcm_ok is masked to 0.
- Reset mid-request: sdram_cs drops immediately (asynchronous), all valid flags clear, and the first access after reset is a demand miss.
- No counters beyond the address incrementer. All arithmetic is AW-bit unsigned with wrap.

Test Plan:
1. Reset, pcm_cs=1, pcm_addr=16'h1234, SDRAM latency 5 returning 8'hA5 -> sdram_cs rises with sdram_addr=1234. Then pcm_data=A5 and pcm_ok=1 on the cycle after sdram_ok. Next, a prefetch request for 16'h1235 appears after a 1-cycle gap.
2. After case 1, prefetch returns 8'h5A; then pcm_addr->1235 -> pcm_ok=0 in the same cycle, pcm_ok=1 with pcm_data=5A one cycle later, with no SDRAM request for 1235. Then a prefetch of 1236 is issued.
3. pcm_addr->16'h4000 (non-sequential) while the 1236 prefetch is in flight -> sdram_cs stays high until sdram_ok for 1236, then drops for 1 cycle, then a request for 4000 follows. pcm_ok stays 0 throughout until the 4000 data returns.
4. Serve pcm_addr=16'hFFFF -> the prefetch address is 16'h0000. Then pcm_addr->0000 -> hit with 1-cycle latency.
5. Drop pcm_cs during FETCH of 16'h0100 -> request completes and pcm_ok stays 0. Raise pcm_cs with the address unchanged -> pcm_ok=1 next cycle with no new request.
6. Assert rst while sdram_cs=1 -> sdram_cs, pcm_ok and pcm_data are 0 immediately. After release with the same address -> a fresh demand request is issued, with no hit from the stale buffer.
